// File: rtl/decoder_3to8_pulse.sv
// Sequential 3-to-8 decoder: accepts a code over valid/ready and drives a timed one-hot strobe.
// Optional macro DEC_QUEUE_EN adds a one-entry code buffer so accepts are legal while busy.
module decoder_3to8_pulse #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic       done
);

  localparam int               HOLD_E  = (HOLD < 1) ? 1 : HOLD;
  localparam bit               HAS_GAP = (GAP > 0);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_E - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = HAS_GAP ? CNT_W'(GAP - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         y_q, y_d;
  logic               yv_q, yv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;
  logic               cnt_zero;
  logic               to_idle;
  logic               start;
  logic [2:0]         start_code;

`ifdef DEC_QUEUE_EN
  logic               buf_full_q, buf_full_d;
  logic [2:0]         buf_code_q, buf_code_d;
`endif

  function automatic logic [7:0] onehot(input logic [2:0] code);
    onehot = 8'd1 << code;
  endfunction

`ifdef DEC_QUEUE_EN
  assign in_ready = !rst && !buf_full_q;
`else
  assign in_ready = !rst && (state_q == S_IDLE);
`endif

  assign accept   = in_valid && in_ready;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    yv_d       = yv_q;
    done_d     = 1'b0;
    to_idle    = 1'b0;
    start      = 1'b0;
    start_code = in_code;
`ifdef DEC_QUEUE_EN
    buf_full_d = buf_full_q;
    buf_code_d = buf_code_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          start = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          y_d    = 8'h00;
          yv_d   = 1'b0;
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            to_idle = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          to_idle = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        y_d     = 8'h00;
        yv_d    = 1'b0;
      end
    endcase

    if (to_idle) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

`ifdef DEC_QUEUE_EN
    // A pending buffered code wins the idle slot; otherwise a same-edge accept bypasses the buffer.
    if (to_idle) begin
      if (buf_full_q) begin
        start      = 1'b1;
        start_code = buf_code_q;
        buf_full_d = 1'b0;
      end else if (accept) begin
        start = 1'b1;
      end
    end else if (accept && (state_q != S_IDLE)) begin
      buf_full_d = 1'b1;
      buf_code_d = in_code;
    end
`endif

    if (start) begin
      state_d = S_HOLD;
      cnt_d   = HOLD_LD;
      y_d     = onehot(start_code);
      yv_d    = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      y_q        <= 8'h00;
      yv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DEC_QUEUE_EN
      buf_full_q <= 1'b0;
      buf_code_q <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      yv_q       <= yv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DEC_QUEUE_EN
      buf_full_q <= buf_full_d;
      buf_code_q <= buf_code_d;
`endif
    end
  end

  assign y       = y_q;
  assign y_valid = yv_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Self-checking bench for decoder_3to8_pulse: directed scenarios plus a randomized timeline model.
module tb_decoder_3to8_pulse;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0, v1;
  logic [2:0] c0, c1;
  logic       r0, r1;
  logic [7:0] y0, y1;
  logic       yv0, yv1, b0, b1, d0, d1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_3to8_pulse #(.HOLD(4), .GAP(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_code(c0),
    .y(y0), .y_valid(yv0), .busy(b0), .done(d0)
  );

  decoder_3to8_pulse #(.HOLD(1), .GAP(0), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_code(c1),
    .y(y1), .y_valid(yv1), .busy(b1), .done(d1)
  );

  // Expected {y, y_valid, busy, done, in_ready} i cycles after an accept, HOLD=4 GAP=1, no queue.
  function automatic logic [11:0] exp_pat(input int i, input logic [2:0] code);
    logic [7:0] oh;
    oh = 8'd1 << code;
    if (i < 4)       return {oh, 4'b1100};
    else if (i == 4) return {8'h00, 4'b0110};
    else             return {8'h00, 4'b0001};
  endfunction

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; c0 = 3'd0; c1 = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    obs = {y0, yv0, b0, d0, r0};
    n_checks++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_hold_u0 got=%h exp=%h", obs, 12'h000); end
    obs = {y1, yv1, b1, d1, r1};
    n_checks++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_hold_u1 got=%h exp=%h", obs, 12'h000); end
    rst = 1'b0;
    #1;
    obs = {y0, yv0, b0, d0, r0};
    n_checks++;
    if (obs !== 12'h001) begin n_fail++; $display("FAIL reset_release_u0 got=%h exp=%h", obs, 12'h001); end
    obs = {y1, yv1, b1, d1, r1};
    n_checks++;
    if (obs !== 12'h001) begin n_fail++; $display("FAIL reset_release_u1 got=%h exp=%h", obs, 12'h001); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [11:0] obs, exp;
    v0 = 1'b1; c0 = 3'd5;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) v0 = 1'b0;
      exp = exp_pat(i, 3'd5);
      obs = {y0, yv0, b0, d0, r0};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL single cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] obs, exp;
    v0 = 1'b1; c0 = 3'd0;
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (r0 !== 1'b1) begin n_fail++; $display("FAIL sweep_ready code=%0d got=%b exp=1", j, r0); end
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (i == 0) begin
          c0 = 3'(j + 1);
          if (j == 7) v0 = 1'b0;
        end
        exp = exp_pat(i, 3'(j));
        obs = {y0, yv0, b0, d0, r0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL sweep code=%0d cyc=%0d got=%h exp=%h", j, i, obs, exp); end
      end
    end
  endtask

  task automatic test_drop();
    logic [11:0] obs, exp;
    v0 = 1'b1; c0 = 3'd2;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        c0 = 3'd6;
        n_checks++;
        if (r0 !== 1'b0) begin n_fail++; $display("FAIL drop_ready got=%b exp=0", r0); end
      end else begin
        v0 = 1'b0;
      end
      exp = exp_pat(i, 3'd2);
      obs = {y0, yv0, b0, d0, r0};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL drop cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_short();
    logic [11:0] obs, exp;
    logic [2:0]  code;
    code = 3'd1;
    v1 = 1'b1; c1 = code;
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (r1 !== 1'b1) begin n_fail++; $display("FAIL short_ready n=%0d got=%b exp=1", j, r1); end
      @(posedge clk); #1;
      exp = {8'd1 << code, 4'b1100};
      obs = {y1, yv1, b1, d1, r1};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL short_hold n=%0d got=%h exp=%h", j, obs, exp); end
      code = code + 3'd3;
      c1 = code;
      if (j == 5) v1 = 1'b0;
      @(posedge clk); #1;
      exp = {8'h00, 4'b0011};
      obs = {y1, yv1, b1, d1, r1};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL short_done n=%0d got=%h exp=%h", j, obs, exp); end
    end
  endtask

  // Timeline model: each accept at edge a owns y over edges a..a+H-1, done at a+H, busy through a+H+G-1.
  task automatic test_random(input int inst, input int H, input int G, input int n);
    int          last_a;
    logic [2:0]  last_code;
    logic        v, rdy, exp_rdy, hold;
    logic [2:0]  c;
    logic [11:0] obs, exp;
    last_a = -1000;
    last_code = 3'd0;
    for (int e = 0; e < n; e++) begin
      v = ($urandom_range(0, 2) != 0);
      c = 3'($urandom_range(0, 7));
      if (inst == 0) begin v0 = v; c0 = c; rdy = r0; end
      else           begin v1 = v; c1 = c; rdy = r1; end
      exp_rdy = (e >= last_a + H + G + 1);
      n_checks++;
      if (rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_ready u%0d e=%0d got=%b exp=%b", inst, e, rdy, exp_rdy); end
      if (v && exp_rdy) begin
        last_a = e;
        last_code = c;
      end
      @(posedge clk); #1;
      hold = (e >= last_a) && (e <= last_a + H - 1);
      exp = {hold ? (8'd1 << last_code) : 8'h00, hold,
             (e >= last_a) && (e <= last_a + H + G - 1),
             (e == last_a + H),
             (e + 1 >= last_a + H + G + 1)};
      obs = (inst == 0) ? {y0, yv0, b0, d0, r0} : {y1, yv1, b1, d1, r1};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL rand_out u%0d e=%0d got=%h exp=%h", inst, e, obs, exp); end
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (H + G + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    logic [11:0] obs;
    v0 = 1'b1; c0 = 3'd3;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (y0 !== 8'h08) begin n_fail++; $display("FAIL midrst_pre got=%h exp=%h", y0, 8'h08); end
    rst = 1'b1;
    #1;
    obs = {y0, yv0, b0, d0, r0};
    n_checks++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL midrst_async got=%h exp=%h", obs, 12'h000); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    obs = {y0, yv0, b0, d0, r0};
    n_checks++;
    if (obs !== 12'h001) begin n_fail++; $display("FAIL midrst_release got=%h exp=%h", obs, 12'h001); end
    v0 = 1'b1; c0 = 3'd1;
    @(posedge clk); #1;
    v0 = 1'b0;
    obs = {y0, yv0, b0, d0, r0};
    n_checks++;
    if (obs !== {8'h02, 4'b1100}) begin n_fail++; $display("FAIL midrst_newcode got=%h exp=%h", obs, {8'h02, 4'b1100}); end
    repeat (6) @(posedge clk);
    #1;
    obs = {y0, yv0, b0, d0, r0};
    n_checks++;
    if (obs !== 12'h001) begin n_fail++; $display("FAIL midrst_idle got=%h exp=%h", obs, 12'h001); end
  endtask

`ifdef DEC_QUEUE_EN
  task automatic test_queue();
    logic [11:0] obs, exp;
    logic [7:0]  ey;
    logic        edone, ebusy, erdy;
    v0 = 1'b1; c0 = 3'd5;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 0) c0 = 3'd2;
      if (i == 1) c0 = 3'd7;
      if (i == 6) v0 = 1'b0;
      if (i <= 3)       ey = 8'h20;
      else if (i == 4)  ey = 8'h00;
      else if (i <= 8)  ey = 8'h04;
      else if (i == 9)  ey = 8'h00;
      else if (i <= 13) ey = 8'h80;
      else              ey = 8'h00;
      edone = (i == 4) || (i == 9) || (i == 14);
      ebusy = (i <= 14);
      erdy  = !((i >= 1 && i <= 4) || (i >= 6 && i <= 9));
      exp = {ey, ey != 8'h00, ebusy, edone, erdy};
      obs = {y0, yv0, b0, d0, r0};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL queue cyc=%0d got=%h exp=%h", i, obs, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef DEC_QUEUE_EN
    test_single();
    test_sweep();
    test_drop();
    test_short();
    test_random(0, 4, 1, 300);
    test_random(1, 1, 0, 300);
`endif
    test_mid_reset();
`ifdef DEC_QUEUE_EN
    test_queue();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
